addr_sequencer: RTL and testbench

- Parametrised successor of the test-address generator: produces a bounded sequence of memory addresses for one test run.
- Supported modes: fixed, LFSR-random (seedable, maskable), running-0, running-1, increment and decrement with stride and wrap inside a [base, limit] window.
- Sits between the CSR test-parameter registers and the memory-transaction builder.
- Delivers addresses over a valid/ready handshake and signals completion after a programmed count.

---
 rtl/addr_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_addr_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/addr_sequencer.sv
// Test-address sequencer: issues a bounded stream of addresses (fixed, LFSR,
// walking 0/1, windowed increment/decrement) over a valid/ready handshake.
module addr_sequencer #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [2:0]        mode_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] limit_addr_i,
  input  logic [ADDR_W-1:0] stride_i,
  input  logic [ADDR_W-1:0] rnd_mask_i,
  input  logic [31:0]       seed_i,
  input  logic [CNT_W-1:0]  count_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              addr_valid_o,
  input  logic              addr_ready_i,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_e;

  localparam logic [2:0] M_FIX  = 3'd0;
  localparam logic [2:0] M_RND  = 3'd1;
  localparam logic [2:0] M_RUN0 = 3'd2;
  localparam logic [2:0] M_RUN1 = 3'd3;
  localparam logic [2:0] M_INC  = 3'd4;
  localparam logic [2:0] M_DEC  = 3'd5;
  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [2:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] base_q, base_d, limit_q, limit_d, stride_q, stride_d, mask_q, mask_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              valid_q, valid_d, busy_q, busy_d, done_q, done_d;

  logic [31:0]       lfsr_seed_s, lfsr_nxt_s;
  logic [ADDR_W:0]   sum_s, diff_s;
  logic [ADDR_W-1:0] first_s, next_s;
  logic              accept_s;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
  endfunction

  function automatic logic [ADDR_W-1:0] rotl1(input logic [ADDR_W-1:0] v);
    return {v[ADDR_W-2:0], v[ADDR_W-1]};
  endfunction

  assign lfsr_seed_s = (seed_i == 32'd0) ? 32'd1 : seed_i;
  assign lfsr_nxt_s  = lfsr_step(lfsr_q);
  assign sum_s       = {1'b0, addr_q} + {1'b0, stride_q};
  assign diff_s      = {1'b0, addr_q} - {1'b0, stride_q};
  assign accept_s    = valid_q & addr_ready_i;

  // First address of a run, derived from the live inputs at start.
  always_comb begin
    first_s = base_addr_i;
    case (mode_i)
      M_RND:   first_s = (lfsr_seed_s[ADDR_W-1:0] & rnd_mask_i) | (base_addr_i & ~rnd_mask_i);
      M_RUN0:  first_s = ~ONE;
      M_RUN1:  first_s = ONE;
      M_INC:   first_s = base_addr_i;
      M_DEC:   first_s = (limit_addr_i < base_addr_i) ? base_addr_i : limit_addr_i;
      default: first_s = base_addr_i;
    endcase
  end

  // Successor address from the latched parameters; an inverted window pins to base.
  always_comb begin
    next_s = base_q;
    case (mode_q)
      M_RND:  next_s = (lfsr_nxt_s[ADDR_W-1:0] & mask_q) | (base_q & ~mask_q);
      M_RUN0: next_s = rotl1(addr_q);
      M_RUN1: next_s = rotl1(addr_q);
      M_INC: begin
        if (limit_q < base_q) begin
          next_s = base_q;
        end else if (sum_s[ADDR_W] || (sum_s[ADDR_W-1:0] > limit_q)) begin
          next_s = base_q;
        end else begin
          next_s = sum_s[ADDR_W-1:0];
        end
      end
      M_DEC: begin
        if (limit_q < base_q) begin
          next_s = base_q;
        end else if (diff_s[ADDR_W] || (diff_s[ADDR_W-1:0] < base_q)) begin
          next_s = limit_q;
        end else begin
          next_s = diff_s[ADDR_W-1:0];
        end
      end
      default: next_s = base_q;
    endcase
  end

  // Sequencer FSM next state, parameter latching and output decode.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    base_d   = base_q;
    limit_d  = limit_q;
    stride_d = stride_q;
    mask_d   = mask_q;
    addr_d   = addr_q;
    lfsr_d   = lfsr_q;
    rem_d    = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          mode_d   = mode_i;
          base_d   = base_addr_i;
          limit_d  = limit_addr_i;
          stride_d = stride_i;
          mask_d   = rnd_mask_i;
          lfsr_d   = lfsr_seed_s;
          rem_d    = count_i;
          addr_d   = first_s;
          state_d  = (count_i != {CNT_W{1'b0}}) ? ST_RUN : ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (accept_s) begin
          rem_d  = rem_q - {{(CNT_W-1){1'b0}}, 1'b1};
          addr_d = next_s;
          lfsr_d = (mode_q == M_RND) ? lfsr_nxt_s : lfsr_q;
          if (rem_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    valid_d = (state_d == ST_RUN);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  // State, parameter and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      mode_q   <= 3'd0;
      base_q   <= '0;
      limit_q  <= '0;
      stride_q <= '0;
      mask_q   <= '0;
      addr_q   <= '0;
      lfsr_q   <= 32'h0000_0001;
      rem_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      base_q   <= base_d;
      limit_q  <= limit_d;
      stride_q <= stride_d;
      mask_q   <= mask_d;
      addr_q   <= addr_d;
      lfsr_q   <= lfsr_d;
      rem_q    <= rem_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign addr_o       = addr_q;
  assign addr_valid_o = valid_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_addr_sequencer.sv
// Scoreboard bench for addr_sequencer: a 32-bit and an 8-bit instance share
// stimulus; expected addresses are queued and popped on every accepted beat.
module tb_addr_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start32 = 1'b0, start8 = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic [31:0] base = 32'd0, limit = 32'd0, stride = 32'd0, mask = 32'd0, seed = 32'd0;
  logic [15:0] count = 16'd0;
  logic        ready = 1'b0;
  logic [31:0] addr32;
  logic        v32, b32, d32;
  logic [7:0]  addr8;
  logic        v8, b8, d8;

  int checks = 0;
  int errors = 0;
  logic [31:0] q32[$];
  logic [7:0]  q8[$];

  always #5 clk = ~clk;

  addr_sequencer #(.ADDR_W(32), .CNT_W(16)) dut32 (
    .clk_i(clk), .rst_i(rst), .start_i(start32), .mode_i(mode),
    .base_addr_i(base), .limit_addr_i(limit), .stride_i(stride),
    .rnd_mask_i(mask), .seed_i(seed), .count_i(count),
    .addr_o(addr32), .addr_valid_o(v32), .addr_ready_i(ready),
    .busy_o(b32), .done_o(d32)
  );

  addr_sequencer #(.ADDR_W(8), .CNT_W(16)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .mode_i(mode),
    .base_addr_i(base[7:0]), .limit_addr_i(limit[7:0]), .stride_i(stride[7:0]),
    .rnd_mask_i(mask[7:0]), .seed_i(seed), .count_i(count),
    .addr_o(addr8), .addr_valid_o(v8), .addr_ready_i(ready),
    .busy_o(b8), .done_o(d8)
  );

  // Monitor: every accepted beat is compared against the head of its queue.
  always @(negedge clk) begin
    if (!rst && v32 && ready) begin
      checks++;
      if (q32.size() == 0) begin
        errors++;
        $display("FAIL beat32: got %h with nothing expected", addr32);
      end else if (addr32 !== q32[0]) begin
        errors++;
        $display("FAIL beat32: got %h expected %h", addr32, q32[0]);
        void'(q32.pop_front());
      end else begin
        void'(q32.pop_front());
      end
    end
    if (!rst && v8 && ready) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL beat8: got %h with nothing expected", addr8);
      end else if (addr8 !== q8[0]) begin
        errors++;
        $display("FAIL beat8: got %h expected %h", addr8, q8[0]);
        void'(q8.pop_front());
      end else begin
        void'(q8.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_start(input bit sel8, input logic [2:0] m, input logic [31:0] b,
                          input logic [31:0] l, input logic [31:0] s, input logic [31:0] mk,
                          input logic [31:0] sd, input logic [15:0] c);
    mode = m; base = b; limit = l; stride = s; mask = mk; seed = sd; count = c;
    if (sel8) start8 = 1'b1;
    else start32 = 1'b1;
    tick();
    start8 = 1'b0;
    start32 = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((b32 || b8) && n < 200) begin
      tick();
      n++;
    end
    chk(nm, {31'd0, (b32 || b8)}, 32'd0);
  endtask

  initial begin
    logic [31:0] inc_exp[6] = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h100, 32'h104};
    logic [31:0] rnd_exp[4] = '{32'h1, 32'h3, 32'h6, 32'hD};
    logic [7:0]  run0_exp[9] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};
    logic [31:0] prev;
    logic        held;

    repeat (3) tick();
    chk("reset addr", addr32, 32'd0);
    chk("reset valid/busy/done", {29'd0, v32, b32, d32}, 32'd0);
    rst = 1'b0;
    ready = 1'b1;
    tick();

    // INC window with wrap, then done/busy timing
    foreach (inc_exp[i]) q32.push_back(inc_exp[i]);
    do_start(1'b0, 3'd4, 32'h100, 32'h10C, 32'd4, 32'd0, 32'd0, 16'd6);
    chk("inc first addr", addr32, 32'h100);
    chk("inc first valid", {31'd0, v32}, 32'd1);
    repeat (6) tick();
    chk("inc done cycle", {29'd0, v32, b32, d32}, 32'h3);
    tick();
    chk("inc idle cycle", {29'd0, v32, b32, d32}, 32'h0);

    // RND with seed 1, then seed 0 gives the same stream
    foreach (rnd_exp[i]) q32.push_back(rnd_exp[i]);
    do_start(1'b0, 3'd1, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1, 16'd4);
    wait_idle("rnd seed1 idle");
    foreach (rnd_exp[i]) q32.push_back(rnd_exp[i]);
    do_start(1'b0, 3'd1, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 16'd4);
    wait_idle("rnd seed0 idle");
    q32.push_back(32'hABCD_1201);
    q32.push_back(32'hABCD_1203);
    do_start(1'b0, 3'd1, 32'hABCD_1200, 32'd0, 32'd0, 32'h0000_00FF, 32'd1, 16'd2);
    wait_idle("rnd masked idle");

    // Walking zero and walking one on the 8-bit instance
    foreach (run0_exp[i]) q8.push_back(run0_exp[i]);
    do_start(1'b1, 3'd2, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 16'd9);
    wait_idle("run0 idle");
    q8.push_back(8'h01); q8.push_back(8'h02); q8.push_back(8'h04);
    do_start(1'b1, 3'd3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 16'd3);
    wait_idle("run1 idle");

    // DEC under back-pressure, with a stray start mid-run
    q32.push_back(32'h20); q32.push_back(32'h18); q32.push_back(32'h10); q32.push_back(32'h20);
    ready = 1'b0;
    do_start(1'b0, 3'd5, 32'h10, 32'h20, 32'd8, 32'd0, 32'd0, 16'd4);
    for (int cyc = 0; cyc < 40 && b32; cyc++) begin
      ready = cyc[0];
      if (cyc == 3) begin
        start32 = 1'b1; mode = 3'd0; base = 32'h55; count = 16'd7;
      end
      held = v32 && !ready;
      prev = addr32;
      tick();
      start32 = 1'b0;
      if (held) chk("hold stable", addr32, prev);
    end
    chk("dec finished", {31'd0, b32}, 32'd0);
    ready = 1'b1;
    tick();

    // count = 0: straight to DONE, no beats
    do_start(1'b0, 3'd4, 32'h40, 32'h80, 32'd1, 32'd0, 32'd0, 16'd0);
    chk("cnt0 N+1", {29'd0, v32, b32, d32}, 32'h3);
    tick();
    chk("cnt0 N+2", {29'd0, v32, b32, d32}, 32'h0);

    // Reset after two of five accepts, then a fresh run
    q32.push_back(32'h200); q32.push_back(32'h201);
    do_start(1'b0, 3'd4, 32'h200, 32'h2FF, 32'd1, 32'd0, 32'd0, 16'd5);
    tick();
    tick();
    rst = 1'b1;
    ready = 1'b0;
    tick();
    chk("abort addr", addr32, 32'd0);
    chk("abort flags", {29'd0, v32, b32, d32}, 32'd0);
    rst = 1'b0;
    tick();
    chk("abort no done", {31'd0, d32}, 32'd0);
    ready = 1'b1;
    q32.push_back(32'h200); q32.push_back(32'h201);
    do_start(1'b0, 3'd4, 32'h200, 32'h2FF, 32'd1, 32'd0, 32'd0, 16'd2);
    chk("restart first addr", addr32, 32'h200);
    wait_idle("restart idle");

    tick();
    chk("q32 drained", q32.size(), 32'd0);
    chk("q8 drained", q8.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
